dp_bram_pipe: RTL and testbench
===============================

Name: dp_bram_pipe

Overview:
- Parametrised true dual-port block RAM for the KAN datapath (coefficient and activation tables).
- Adds three things the first-generation inferred BRAM lacks: configurable output pipeline depth, per-port write mode, and registered read-valid strobes.
- Detects same-address port collisions and counts them, so a controller can flag table-update hazards.
- Both ports share one clock; the array itself infers as BRAM with the pipeline in fabric/output registers.

Parameters:
- DATA_WIDTH, 32: word width in bits; must be a multiple of 8.
- ADDR_WIDTH, 10: address width; DEPTH = 2**ADDR_WIDTH words.
- STRB_WIDTH, DATA_WIDTH/8: byte-strobe count.
- READ_LATENCY, 2: cycles from op to dout/valid; legal range 1..4.
- WRITE_MODE_A, 0: port A write mode; 0 READ_FIRST, 1 WRITE_FIRST, 2 NO_CHANGE.
- WRITE_MODE_B, 0: port B write mode; same encoding as WRITE_MODE_A.
- CNT_WIDTH, 16: width of the collision counter.

Ports:
- clk  in  1  single clock for both ports.
- rst  in  1  synchronous, active-high reset.
- ena  in  1  port A op enable.
- wea  in  STRB_WIDTH  port A byte write strobes; any bit set makes the op a write, all clear makes it a read.
- addra  in  ADDR_WIDTH  port A address.
- dina  in  DATA_WIDTH  port A write data.
- douta  out  DATA_WIDTH  port A read data.
- douta_valid  out  1  douta is valid this cycle.
- enb, web, addrb, dinb, doutb, doutb_valid: port B, identical to port A.
- collision  out  1  one-cycle pulse, one cycle after a collision.
- collision_cnt  out  CNT_WIDTH  saturating count of collisions.

Behaviour:
- Reset: douta, doutb and every pipeline stage clear to 0; both valids, collision and collision_cnt clear to 0. Memory contents are not reset.
- Ops presented in a cycle with rst=1 are ignored: no write occurs and no valid is produced. Asserting rst mid-pipeline drops every in-flight read.
- Port op in cycle T (en=1, rst=0): dout and dout_valid present the result at rising edge T+READ_LATENCY.
  - Stage 1 is the array output register; stages 2..READ_LATENCY are plain registers.
  - No backpressure: the pipeline advances every cycle and accepts one op per port per cycle.
- Reads (en=1, we=0): valid=1 at T+L and dout = mem[addr] as it stood before cycle T's writes.
- Writes: only bytes with strobe=1 change; other bytes are kept.
  - READ_FIRST: dout = old word, valid=1.
  - WRITE_FIRST: dout = merged new word, valid=1.
  - NO_CHANGE: no valid is produced, and dout holds its last value.
- When valid=0, dout holds its previous value and does not go to zero.
- Collision: both ports enabled, addra==addrb, at least one port writing, rst=0.
  - Write/write: per byte, port B wins where both strobes are set; the union of strobed bytes is written.
  - Read/write: the reading port returns the old word (read-first across ports); the writing port follows its own mode.
  - Read/read: not a collision.
  - On a collision, collision=1 in cycle T+1 and collision_cnt increments in the same edge, saturating at all-ones.
- Address wrap: addresses are native width, so no out-of-range access exists.
- READ_LATENCY outside 1..4, or DATA_WIDTH%8 != 0, is an elaboration error.

Decomposition:
- Shared package kan_mem_pkg:
  - Constants WMODE_READ_FIRST=0, WMODE_WRITE_FIRST=1, WMODE_NO_CHANGE=2.
  - MAX_READ_LATENCY=4.
  - Function byte_merge(old, new, strb).
- One sub-module, bram_out_pipe: parametrised by DATA_WIDTH and depth READ_LATENCY-1, carrying a data+valid shift register with synchronous reset. Instantiated once per port.
- The array, collision logic and counter stay in dp_bram_pipe.

Test Plan:
- L=2, READ_FIRST on both ports. Write A addr 0x010 data 0xDEADBEEF strb 0xF, then read B addr 0x010 in the next cycle -> doutb=0xDEADBEEF with valid exactly 2 cycles after the read. The write's own douta_valid pulse carries the old word.
- Byte strobes. mem[5]=0x11223344, then A writes 0xAABBCCDD strb 0x5, then read 5 -> 0x11BB33DD.
- Write modes, A=WRITE_FIRST, B=NO_CHANGE. A writes 0x12345678 to addr 3 -> douta=0x12345678, valid at T+L. B writes addr 4 -> doutb_valid stays 0 and doutb unchanged.
- Write/write collision. Both ports write addr 7 in the same cycle, A=0xFFFFFFFF strb 0xF, B=0x00000000 strb 0x3 -> mem[7]=0xFFFF0000. collision=1 at T+1 and collision_cnt=1. Repeat 2**CNT_WIDTH+5 times -> count saturates at all-ones.
- Reset mid-flight, L=4. Issue reads at T and T+1, assert rst at T+2 for one cycle -> no valid pulse ever appears, dout=0. A write issued in the reset cycle leaves memory unchanged.
- Back-to-back streaming. Read addresses 0..63 on both ports every cycle, L=1 and L=3 -> 64 consecutive valid cycles with data in address order and no bubbles.

Source files
------------

// File: rtl/kan_mem_pkg.sv
// Shared constants and helpers for the KAN datapath memories.
package kan_mem_pkg;

    localparam int WMODE_READ_FIRST  = 0;
    localparam int WMODE_WRITE_FIRST = 1;
    localparam int WMODE_NO_CHANGE   = 2;

    localparam int MAX_READ_LATENCY  = 4;

    // Widest word the merge helper handles; instances zero-extend into it.
    localparam int MAX_DATA_WIDTH    = 256;
    localparam int MAX_STRB_WIDTH    = MAX_DATA_WIDTH / 8;

    // Replace the bytes of old_word selected by strb with those of new_word.
    function automatic logic [MAX_DATA_WIDTH-1:0] byte_merge(
        input logic [MAX_DATA_WIDTH-1:0] old_word,
        input logic [MAX_DATA_WIDTH-1:0] new_word,
        input logic [MAX_STRB_WIDTH-1:0] strb
    );
        logic [MAX_DATA_WIDTH-1:0] merged;
        merged = old_word;
        for (int i = 0; i < MAX_STRB_WIDTH; i++) begin
            if (strb[i]) begin
                merged[i*8 +: 8] = new_word[i*8 +: 8];
            end
        end
        return merged;
    endfunction

endpackage

// File: rtl/bram_out_pipe.sv
// Read-data pipeline behind the array output register: data+valid shift
// register whose data only moves with a valid, so idle cycles hold dout.
module bram_out_pipe #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] din,
    input  logic                  din_valid,
    output logic [DATA_WIDTH-1:0] dout,
    output logic                  dout_valid
);

    generate
        if (DEPTH == 0) begin : g_bypass
            assign dout       = din;
            assign dout_valid = din_valid;
        end else begin : g_stages
            logic [DATA_WIDTH-1:0] stage_data  [DEPTH];
            logic                  stage_valid [DEPTH];

            // Shift valid every cycle; shift data only alongside a valid.
            always_ff @(posedge clk) begin
                if (rst) begin
                    for (int i = 0; i < DEPTH; i++) begin
                        stage_data[i]  <= '0;
                        stage_valid[i] <= 1'b0;
                    end
                end else begin
                    stage_valid[0] <= din_valid;
                    if (din_valid) begin
                        stage_data[0] <= din;
                    end
                    for (int i = 1; i < DEPTH; i++) begin
                        stage_valid[i] <= stage_valid[i-1];
                        if (stage_valid[i-1]) begin
                            stage_data[i] <= stage_data[i-1];
                        end
                    end
                end
            end

            assign dout       = stage_data[DEPTH-1];
            assign dout_valid = stage_valid[DEPTH-1];
        end
    endgenerate

endmodule

// File: rtl/dp_bram_pipe.sv
// True dual-port BRAM with per-port write mode, configurable read latency,
// registered read-valid strobes and same-address collision counting.
module dp_bram_pipe
    import kan_mem_pkg::*;
#(
    parameter int DATA_WIDTH   = 32,
    parameter int ADDR_WIDTH   = 10,
    parameter int STRB_WIDTH   = DATA_WIDTH / 8,
    parameter int READ_LATENCY = 2,
    parameter int WRITE_MODE_A = 0,
    parameter int WRITE_MODE_B = 0,
    parameter int CNT_WIDTH    = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ena,
    input  logic [STRB_WIDTH-1:0] wea,
    input  logic [ADDR_WIDTH-1:0] addra,
    input  logic [DATA_WIDTH-1:0] dina,
    output logic [DATA_WIDTH-1:0] douta,
    output logic                  douta_valid,
    input  logic                  enb,
    input  logic [STRB_WIDTH-1:0] web,
    input  logic [ADDR_WIDTH-1:0] addrb,
    input  logic [DATA_WIDTH-1:0] dinb,
    output logic [DATA_WIDTH-1:0] doutb,
    output logic                  doutb_valid,
    output logic                  collision,
    output logic [CNT_WIDTH-1:0]  collision_cnt
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;

    generate
        if (READ_LATENCY < 1 || READ_LATENCY > MAX_READ_LATENCY) begin : g_bad_latency
            $error("dp_bram_pipe: READ_LATENCY must be 1..%0d", MAX_READ_LATENCY);
        end
        if (DATA_WIDTH % 8 != 0 || DATA_WIDTH > MAX_DATA_WIDTH) begin : g_bad_width
            $error("dp_bram_pipe: DATA_WIDTH must be a multiple of 8 up to %0d", MAX_DATA_WIDTH);
        end
        if (STRB_WIDTH != DATA_WIDTH / 8) begin : g_bad_strb
            $error("dp_bram_pipe: STRB_WIDTH must equal DATA_WIDTH/8");
        end
        if (WRITE_MODE_A > WMODE_NO_CHANGE || WRITE_MODE_B > WMODE_NO_CHANGE) begin : g_bad_mode
            $error("dp_bram_pipe: write mode must be 0..2");
        end
    endgenerate

    function automatic logic [DATA_WIDTH-1:0] merge_word(
        input logic [DATA_WIDTH-1:0] old_word,
        input logic [DATA_WIDTH-1:0] new_word,
        input logic [STRB_WIDTH-1:0] strb
    );
        return DATA_WIDTH'(byte_merge(MAX_DATA_WIDTH'(old_word),
                                      MAX_DATA_WIDTH'(new_word),
                                      MAX_STRB_WIDTH'(strb)));
    endfunction

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic [DATA_WIDTH-1:0] old_a, old_b;
    logic [DATA_WIDTH-1:0] new_a, new_b, wf_a;
    logic                  op_a, op_b, wr_a, wr_b, ww_hit, hit;
    logic                  rd_vld_a, rd_vld_b;
    logic [DATA_WIDTH-1:0] s1_data_a, s1_data_b;
    logic                  s1_valid_a, s1_valid_b;

    assign old_a = mem[addra];
    assign old_b = mem[addrb];

    // Decode this cycle's ops, collision class and the words to be written.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves one unassigned and infers a latch.
        op_a     = 1'b0;
        op_b     = 1'b0;
        wr_a     = 1'b0;
        wr_b     = 1'b0;
        ww_hit   = 1'b0;
        hit      = 1'b0;
        rd_vld_a = 1'b0;
        rd_vld_b = 1'b0;
        new_a    = old_a;
        new_b    = old_b;
        wf_a     = old_a;

        op_a   = ena && !rst;
        op_b   = enb && !rst;
        wr_a   = op_a && (|wea);
        wr_b   = op_b && (|web);
        hit    = op_a && op_b && (addra == addrb) && (wr_a || wr_b);
        ww_hit = hit && wr_a && wr_b;

        // Port B is merged over port A's result so B wins on shared bytes.
        new_a = merge_word(old_a, dina, wea);
        new_b = merge_word(ww_hit ? new_a : old_b, dinb, web);
        wf_a  = ww_hit ? new_b : new_a;

        rd_vld_a = op_a && !(wr_a && WRITE_MODE_A == WMODE_NO_CHANGE);
        rd_vld_b = op_b && !(wr_b && WRITE_MODE_B == WMODE_NO_CHANGE);
    end

    // Array write; a same-address double write is committed once via port B.
    always_ff @(posedge clk) begin
        // NOTE: the array has no reset so it maps onto block RAM; only the pipeline and flags are cleared.
        if (wr_a && !ww_hit) begin
            mem[addra] <= new_a;
        end
        if (wr_b) begin
            mem[addrb] <= new_b;
        end
    end

    // Array output register for port A (pipeline stage 1).
    always_ff @(posedge clk) begin
        // NOTE: state updates use <= so every register samples pre-edge values regardless of block order.
        if (rst) begin
            s1_data_a  <= '0;
            s1_valid_a <= 1'b0;
        end else begin
            s1_valid_a <= rd_vld_a;
            if (rd_vld_a) begin
                s1_data_a <= (wr_a && WRITE_MODE_A == WMODE_WRITE_FIRST) ? wf_a : old_a;
            end
        end
    end

    // Array output register for port B (pipeline stage 1).
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_data_b  <= '0;
            s1_valid_b <= 1'b0;
        end else begin
            s1_valid_b <= rd_vld_b;
            if (rd_vld_b) begin
                s1_data_b <= (wr_b && WRITE_MODE_B == WMODE_WRITE_FIRST) ? new_b : old_b;
            end
        end
    end

    // Collision pulse and saturating counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            collision     <= 1'b0;
            collision_cnt <= '0;
        end else begin
            collision <= hit;
            if (hit && collision_cnt != {CNT_WIDTH{1'b1}}) begin
                collision_cnt <= collision_cnt + CNT_WIDTH'(1);
            end
        end
    end

    bram_out_pipe #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (READ_LATENCY - 1)
    ) u_pipe_a (
        .clk        (clk),
        .rst        (rst),
        .din        (s1_data_a),
        .din_valid  (s1_valid_a),
        .dout       (douta),
        .dout_valid (douta_valid)
    );

    bram_out_pipe #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (READ_LATENCY - 1)
    ) u_pipe_b (
        .clk        (clk),
        .rst        (rst),
        .din        (s1_data_b),
        .din_valid  (s1_valid_b),
        .dout       (doutb),
        .dout_valid (doutb_valid)
    );

endmodule

// File: tb/tb_dp_bram_pipe.sv
// Self-checking bench: five instances share one stimulus stream and differ
// only in latency / write mode, so each corner is observed on the relevant one.
module tb_dp_bram_pipe;

    localparam int DW = 32;
    localparam int AW = 10;
    localparam int SW = 4;
    localparam int CW = 4;
    localparam int N_INST = 5;
    // Instance indices
    localparam int I_L2    = 0;   // L=2, READ_FIRST / READ_FIRST
    localparam int I_MODES = 1;   // L=2, WRITE_FIRST / NO_CHANGE
    localparam int I_L4    = 2;   // L=4, READ_FIRST / READ_FIRST
    localparam int I_L1    = 3;   // L=1
    localparam int I_L3    = 4;   // L=3

    logic          clk = 1'b0;
    logic          rst;
    logic          ena, enb;
    logic [SW-1:0] wea, web;
    logic [AW-1:0] addra, addrb;
    logic [DW-1:0] dina, dinb;

    logic [DW-1:0] douta_x [N_INST];
    logic [DW-1:0] doutb_x [N_INST];
    logic          va_x    [N_INST];
    logic          vb_x    [N_INST];
    logic          coll_x  [N_INST];
    logic [CW-1:0] cnt_x   [N_INST];

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    dp_bram_pipe #(.READ_LATENCY(2), .WRITE_MODE_A(0), .WRITE_MODE_B(0), .CNT_WIDTH(CW)) u_l2 (
        .clk(clk), .rst(rst),
        .ena(ena), .wea(wea), .addra(addra), .dina(dina), .douta(douta_x[I_L2]), .douta_valid(va_x[I_L2]),
        .enb(enb), .web(web), .addrb(addrb), .dinb(dinb), .doutb(doutb_x[I_L2]), .doutb_valid(vb_x[I_L2]),
        .collision(coll_x[I_L2]), .collision_cnt(cnt_x[I_L2]));

    dp_bram_pipe #(.READ_LATENCY(2), .WRITE_MODE_A(1), .WRITE_MODE_B(2), .CNT_WIDTH(CW)) u_modes (
        .clk(clk), .rst(rst),
        .ena(ena), .wea(wea), .addra(addra), .dina(dina), .douta(douta_x[I_MODES]), .douta_valid(va_x[I_MODES]),
        .enb(enb), .web(web), .addrb(addrb), .dinb(dinb), .doutb(doutb_x[I_MODES]), .doutb_valid(vb_x[I_MODES]),
        .collision(coll_x[I_MODES]), .collision_cnt(cnt_x[I_MODES]));

    dp_bram_pipe #(.READ_LATENCY(4), .WRITE_MODE_A(0), .WRITE_MODE_B(0), .CNT_WIDTH(CW)) u_l4 (
        .clk(clk), .rst(rst),
        .ena(ena), .wea(wea), .addra(addra), .dina(dina), .douta(douta_x[I_L4]), .douta_valid(va_x[I_L4]),
        .enb(enb), .web(web), .addrb(addrb), .dinb(dinb), .doutb(doutb_x[I_L4]), .doutb_valid(vb_x[I_L4]),
        .collision(coll_x[I_L4]), .collision_cnt(cnt_x[I_L4]));

    dp_bram_pipe #(.READ_LATENCY(1), .WRITE_MODE_A(0), .WRITE_MODE_B(0), .CNT_WIDTH(CW)) u_l1 (
        .clk(clk), .rst(rst),
        .ena(ena), .wea(wea), .addra(addra), .dina(dina), .douta(douta_x[I_L1]), .douta_valid(va_x[I_L1]),
        .enb(enb), .web(web), .addrb(addrb), .dinb(dinb), .doutb(doutb_x[I_L1]), .doutb_valid(vb_x[I_L1]),
        .collision(coll_x[I_L1]), .collision_cnt(cnt_x[I_L1]));

    dp_bram_pipe #(.READ_LATENCY(3), .WRITE_MODE_A(0), .WRITE_MODE_B(0), .CNT_WIDTH(CW)) u_l3 (
        .clk(clk), .rst(rst),
        .ena(ena), .wea(wea), .addra(addra), .dina(dina), .douta(douta_x[I_L3]), .douta_valid(va_x[I_L3]),
        .enb(enb), .web(web), .addrb(addrb), .dinb(dinb), .doutb(doutb_x[I_L3]), .doutb_valid(vb_x[I_L3]),
        .collision(coll_x[I_L3]), .collision_cnt(cnt_x[I_L3]));

    typedef struct {
        logic          ena;
        logic [SW-1:0] wea;
        logic [AW-1:0] addra;
        logic [DW-1:0] dina;
        logic          enb;
        logic [SW-1:0] web;
        logic [AW-1:0] addrb;
        logic [DW-1:0] dinb;
        logic          exp_va;
        logic [DW-1:0] exp_da;
        logic          exp_vb;
        logic [DW-1:0] exp_db;
    } vec_t;

    localparam int NV = 7;
    vec_t vecs [NV];

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_bit(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic ea, input logic [SW-1:0] wa, input logic [AW-1:0] aa, input logic [DW-1:0] da,
                         input logic eb, input logic [SW-1:0] wb, input logic [AW-1:0] ab, input logic [DW-1:0] db);
        ena = ea; wea = wa; addra = aa; dina = da;
        enb = eb; web = wb; addrb = ab; dinb = db;
    endtask

    task automatic idle();
        drive(1'b0, '0, '0, '0, 1'b0, '0, '0, '0);
    endtask

    function automatic logic [DW-1:0] pat(input int i);
        logic [DW-1:0] v;
        v = DW'(i);
        return 32'hA5A5_0000 ^ (v * 32'h0101_0101);
    endfunction

    // Bound on total run time.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vec_t v;
        int   j;
        logic [CW-1:0] exp_cnt;

        //            ena wea    addra   dina          enb web    addrb   dinb          va  da            vb  db
        vecs[0] = '{1'b1, 4'hF, 10'h010, 32'hDEADBEEF, 1'b1, 4'h0, 10'h005, 32'h0,        1'b1, 32'h01010101, 1'b1, 32'h11223344};
        vecs[1] = '{1'b1, 4'h5, 10'h005, 32'hAABBCCDD, 1'b1, 4'h0, 10'h010, 32'h0,        1'b1, 32'h11223344, 1'b1, 32'hDEADBEEF};
        vecs[2] = '{1'b1, 4'h0, 10'h005, 32'h0,        1'b0, 4'h0, 10'h000, 32'h0,        1'b1, 32'h11BB33DD, 1'b0, 32'h0};
        vecs[3] = '{1'b0, 4'h0, 10'h000, 32'h0,        1'b1, 4'h0, 10'h010, 32'h0,        1'b0, 32'h0,        1'b1, 32'hDEADBEEF};
        vecs[4] = '{1'b1, 4'h0, 10'h004, 32'h0,        1'b1, 4'h0, 10'h005, 32'h0,        1'b1, 32'h55555555, 1'b1, 32'h11BB33DD};
        vecs[5] = '{1'b1, 4'h0, 10'h004, 32'h0,        1'b1, 4'hF, 10'h004, 32'h66666666, 1'b1, 32'h55555555, 1'b1, 32'h55555555};
        vecs[6] = '{1'b1, 4'h0, 10'h004, 32'h0,        1'b0, 4'h0, 10'h000, 32'h0,        1'b1, 32'h66666666, 1'b0, 32'h0};

        // ---------------- reset state ----------------
        rst = 1'b1;
        idle();
        repeat (3) tick();
        for (int k = 0; k < N_INST; k++) begin
            check("reset douta", douta_x[k], 32'h0);
            check("reset doutb", doutb_x[k], 32'h0);
            check_bit("reset douta_valid", va_x[k], 1'b0);
            check_bit("reset doutb_valid", vb_x[k], 1'b0);
            check_bit("reset collision", coll_x[k], 1'b0);
            check("reset collision_cnt", 32'(cnt_x[k]), 32'h0);
        end
        rst = 1'b0;

        // ---------------- preload ----------------
        drive(1'b1, 4'hF, 10'h010, 32'h01010101, 1'b1, 4'hF, 10'h005, 32'h11223344); tick();
        drive(1'b1, 4'hF, 10'h003, 32'h00000000, 1'b1, 4'hF, 10'h004, 32'h55555555); tick();
        drive(1'b1, 4'hF, 10'h007, 32'h00000000, 1'b0, 4'h0, 10'h000, 32'h0);        tick();
        idle();
        repeat (4) tick();

        // ---------------- table: L=2 READ_FIRST ----------------
        for (int i = 0; i <= NV; i++) begin
            if (i < NV) begin
                drive(vecs[i].ena, vecs[i].wea, vecs[i].addra, vecs[i].dina,
                      vecs[i].enb, vecs[i].web, vecs[i].addrb, vecs[i].dinb);
            end else begin
                idle();
            end
            tick();
            if (i >= 1) begin
                v = vecs[i-1];
                check_bit($sformatf("vec%0d douta_valid", i-1), va_x[I_L2], v.exp_va);
                check_bit($sformatf("vec%0d doutb_valid", i-1), vb_x[I_L2], v.exp_vb);
                if (v.exp_va) check($sformatf("vec%0d douta", i-1), douta_x[I_L2], v.exp_da);
                if (v.exp_vb) check($sformatf("vec%0d doutb", i-1), doutb_x[I_L2], v.exp_db);
            end
        end
        check("table collision_cnt", 32'(cnt_x[I_L2]), 32'd1);

        // ---------------- write modes: A WRITE_FIRST, B NO_CHANGE ----------------
        drive(1'b1, 4'hF, 10'h003, 32'h12345678, 1'b1, 4'hF, 10'h004, 32'h77777777);
        tick();
        idle();
        check_bit("wf early douta_valid", va_x[I_MODES], 1'b0);
        check("wf early douta hold", douta_x[I_MODES], 32'h66666666);
        tick();
        check_bit("wf douta_valid", va_x[I_MODES], 1'b1);
        check("wf douta", douta_x[I_MODES], 32'h12345678);
        check_bit("nc doutb_valid", vb_x[I_MODES], 1'b0);
        check("nc doutb hold", doutb_x[I_MODES], 32'h11BB33DD);
        check("rf douta old", douta_x[I_L2], 32'h00000000);
        check("rf doutb old", doutb_x[I_L2], 32'h66666666);
        tick();
        check_bit("wf pulse ends", va_x[I_MODES], 1'b0);
        check("wf douta hold", douta_x[I_MODES], 32'h12345678);
        drive(1'b0, 4'h0, 10'h000, 32'h0, 1'b1, 4'h0, 10'h004, 32'h0);
        tick();
        idle();
        tick();
        check_bit("nc readback valid", vb_x[I_MODES], 1'b1);
        check("nc readback data", doutb_x[I_MODES], 32'h77777777);

        // ---------------- reset mid-flight, L=4 ----------------
        drive(1'b1, 4'h0, 10'h005, 32'h0, 1'b1, 4'h0, 10'h005, 32'h0);
        tick();
        check_bit("read/read no collision", coll_x[I_L2], 1'b0);
        drive(1'b1, 4'h0, 10'h003, 32'h0, 1'b1, 4'h0, 10'h004, 32'h0);
        tick();
        rst = 1'b1;
        drive(1'b1, 4'hF, 10'h005, 32'h99999999, 1'b0, 4'h0, 10'h000, 32'h0);
        tick();
        rst = 1'b0;
        idle();
        for (int k = 0; k < 6; k++) begin
            check_bit($sformatf("rst l4 douta_valid c%0d", k), va_x[I_L4], 1'b0);
            check_bit($sformatf("rst l4 doutb_valid c%0d", k), vb_x[I_L4], 1'b0);
            check($sformatf("rst l4 douta c%0d", k), douta_x[I_L4], 32'h0);
            check($sformatf("rst l4 doutb c%0d", k), doutb_x[I_L4], 32'h0);
            tick();
        end
        check("rst collision_cnt", 32'(cnt_x[I_L2]), 32'h0);
        drive(1'b1, 4'h0, 10'h005, 32'h0, 1'b0, 4'h0, 10'h000, 32'h0);
        tick();
        idle();
        repeat (3) tick();
        check_bit("post-rst read valid", va_x[I_L4], 1'b1);
        check("write during rst ignored", douta_x[I_L4], 32'h11BB33DD);

        // ---------------- write/write collision + saturation ----------------
        drive(1'b1, 4'hF, 10'h007, 32'hFFFFFFFF, 1'b1, 4'h3, 10'h007, 32'h00000000);
        tick();
        idle();
        check_bit("ww collision pulse", coll_x[I_L2], 1'b1);
        check("ww collision_cnt", 32'(cnt_x[I_L2]), 32'd1);
        tick();
        check_bit("ww collision pulse ends", coll_x[I_L2], 1'b0);
        check("ww collision_cnt hold", 32'(cnt_x[I_L2]), 32'd1);
        drive(1'b1, 4'h0, 10'h007, 32'h0, 1'b0, 4'h0, 10'h000, 32'h0);
        tick();
        idle();
        tick();
        check_bit("ww readback valid", va_x[I_L2], 1'b1);
        check("ww merged word", douta_x[I_L2], 32'hFFFF0000);
        for (int k = 2; k <= (1 << CW) + 5; k++) begin
            drive(1'b1, 4'hF, 10'h007, 32'hFFFFFFFF, 1'b1, 4'h3, 10'h007, 32'h00000000);
            tick();
            exp_cnt = (k >= (1 << CW) - 1) ? {CW{1'b1}} : CW'(k);
            check($sformatf("sat cnt after %0d", k), 32'(cnt_x[I_L2]), 32'(exp_cnt));
        end
        idle();
        tick();
        check("sat cnt final", 32'(cnt_x[I_L2]), 32'(CW'({CW{1'b1}})));

        // ---------------- streaming, L=1 and L=3 ----------------
        for (int i = 0; i < 32; i++) begin
            drive(1'b1, 4'hF, AW'(i), pat(i), 1'b1, 4'hF, AW'(32 + i), pat(32 + i));
            tick();
        end
        idle();
        repeat (5) tick();
        for (int c = 0; c < 67; c++) begin
            if (c < 64) drive(1'b1, 4'h0, AW'(c), 32'h0, 1'b1, 4'h0, AW'(63 - c), 32'h0);
            else        idle();
            tick();
            if (c < 64) begin
                check_bit($sformatf("l1 va c%0d", c), va_x[I_L1], 1'b1);
                check_bit($sformatf("l1 vb c%0d", c), vb_x[I_L1], 1'b1);
                check($sformatf("l1 da c%0d", c), douta_x[I_L1], pat(c));
                check($sformatf("l1 db c%0d", c), doutb_x[I_L1], pat(63 - c));
            end else begin
                check_bit($sformatf("l1 va tail c%0d", c), va_x[I_L1], 1'b0);
            end
            j = c - 2;
            if (j >= 0 && j < 64) begin
                check_bit($sformatf("l3 va j%0d", j), va_x[I_L3], 1'b1);
                check_bit($sformatf("l3 vb j%0d", j), vb_x[I_L3], 1'b1);
                check($sformatf("l3 da j%0d", j), douta_x[I_L3], pat(j));
                check($sformatf("l3 db j%0d", j), doutb_x[I_L3], pat(63 - j));
            end else begin
                check_bit($sformatf("l3 va edge c%0d", c), va_x[I_L3], 1'b0);
            end
        end
        tick();
        check_bit("l3 va tail", va_x[I_L3], 1'b0);
        check("l3 da hold", douta_x[I_L3], pat(63));

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
